pulse_shift_reg: RTL and testbench

//  Consumes the debounced one-cycle pulses produced by the push-button one-shot

---
 rtl/pulse_shift_reg_if.sv | 37 +++
 rtl/pulse_shift_reg.sv | 147 ++++++++++++++
 tb/tb_pulse_shift_reg.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_shift_reg_if.sv
// Bus between the push-button one-shot stage (master) and pulse_shift_reg (slave).
// With PSR_UNDO_EN defined the bus also carries the undo pulse.
interface pulse_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    // Handshake: step/load/undo are one-cycle pulses with no ready; a pulse the
    // slave cannot take (busy, or lower priority) is dropped, never queued.
    // done is the slave's one-cycle valid: q/ser_out/step_cnt hold the result.
    logic             step;
    logic             load;
    logic             burst;
    logic [1:0]       mode;
    logic             ser_in;
    logic [WIDTH-1:0] par_in;
`ifdef PSR_UNDO_EN
    logic             undo;
`endif
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] step_cnt;
    logic             state_dbg;

`ifdef PSR_UNDO_EN
    modport master (output step, load, burst, mode, ser_in, par_in, undo,
                    input  q, ser_out, busy, done, step_cnt, state_dbg);
    modport slave  (input  step, load, burst, mode, ser_in, par_in, undo,
                    output q, ser_out, busy, done, step_cnt, state_dbg);
`else
    modport master (output step, load, burst, mode, ser_in, par_in,
                    input  q, ser_out, busy, done, step_cnt, state_dbg);
    modport slave  (input  step, load, burst, mode, ser_in, par_in,
                    output q, ser_out, busy, done, step_cnt, state_dbg);
`endif
endinterface

// File: rtl/pulse_shift_reg.sv
// Pulse-driven shift register: load, single step or BURST-shift burst in four modes.
// Optional one-deep undo snapshot when PSR_UNDO_EN is defined.
module pulse_shift_reg #(
    parameter int WIDTH = 8,
    parameter int BURST = 4,
    parameter int CNT_W = 8
) (
    input logic              clk_in,
    input logic              rst,
    pulse_shift_reg_if.slave bus
);
    localparam int REM_W = $clog2(BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ser_q, ser_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [REM_W-1:0] rem_q, rem_d;
`ifdef PSR_UNDO_EN
    logic [WIDTH-1:0] snap_q, snap_d;
    logic             snap_v_q, snap_v_d;
`endif

    logic [1:0]     shift_mode;
    logic [WIDTH:0] shifted;

    // Returns {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] shift_op(input logic [1:0] m,
                                                input logic [WIDTH-1:0] v,
                                                input logic si);
        case (m)
            2'b00:   return {v[0],       si,         v[WIDTH-1:1]};
            2'b01:   return {v[WIDTH-1], v[WIDTH-2:0], si};
            2'b10:   return {v[0],       v[0],       v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
        endcase
    endfunction

    // Burst shifts use the mode latched at the step; ser_in is always live.
    assign shift_mode = (state_q == S_BURST) ? mode_q : bus.mode;
    assign shifted    = shift_op(shift_mode, shreg_q, bus.ser_in);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        ser_d    = ser_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        rem_d    = rem_q;
`ifdef PSR_UNDO_EN
        snap_d   = snap_q;
        snap_v_d = snap_v_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    shreg_d = bus.par_in;
                    done_d  = 1'b1;
`ifdef PSR_UNDO_EN
                    snap_d   = shreg_q;
                    snap_v_d = 1'b1;
`endif
                end else if (bus.step) begin
                    shreg_d = shifted[WIDTH-1:0];
                    ser_d   = shifted[WIDTH];
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef PSR_UNDO_EN
                    snap_d   = shreg_q;
                    snap_v_d = 1'b1;
`endif
                    if (bus.burst && (BURST > 1)) begin
                        mode_d  = bus.mode;
                        rem_d   = REM_W'(BURST - 1);
                        state_d = S_BURST;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
`ifdef PSR_UNDO_EN
                end else if (bus.undo && snap_v_q) begin
                    shreg_d  = snap_q;
                    snap_v_d = 1'b0;
                    done_d   = 1'b1;
`endif
                end
            end
            default: begin
                shreg_d = shifted[WIDTH-1:0];
                ser_d   = shifted[WIDTH];
                rem_d   = rem_q - REM_W'(1);
                if (rem_q == REM_W'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // Asynchronous reset aborts any burst in progress; nothing partial survives.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            ser_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= 2'b00;
            rem_q    <= '0;
`ifdef PSR_UNDO_EN
            snap_q   <= '0;
            snap_v_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            ser_q    <= ser_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            rem_q    <= rem_d;
`ifdef PSR_UNDO_EN
            snap_q   <= snap_d;
            snap_v_q <= snap_v_d;
`endif
        end
    end

    assign bus.q         = shreg_q;
    assign bus.ser_out   = ser_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.step_cnt  = cnt_q;
    assign bus.state_dbg = (state_q == S_BURST);
endmodule

// File: tb/tb_pulse_shift_reg.sv
// Directed bench for pulse_shift_reg (WIDTH=8, BURST=4, CNT_W=8); done-triggered scoreboard.
// Define PSR_UNDO_EN to also exercise the undo path.
module tb_pulse_shift_reg;
    logic clk_in;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard entry: {q, ser_out, step_cnt}
    logic [16:0] exp_q[$];

    pulse_shift_reg_if #(.WIDTH(8), .CNT_W(8)) bus ();

    pulse_shift_reg #(.WIDTH(8), .BURST(4), .CNT_W(8)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    // Clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk_in) begin
        if (!rst && bus.done) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: got q=%h ser=%b cnt=%0d, required no done",
                         bus.q, bus.ser_out, bus.step_cnt);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({bus.q, bus.ser_out, bus.step_cnt} !== e) begin
                    n_err++;
                    $display("FAIL done_result: got q=%h ser=%b cnt=%0d, required q=%h ser=%b cnt=%0d",
                             bus.q, bus.ser_out, bus.step_cnt, e[16:9], e[8], e[7:0]);
                end
            end
        end
    end

    // Driver tasks; each is entered and left 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] q, input logic ser, input logic [7:0] cnt);
        exp_q.push_back({q, ser, cnt});
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.par_in = v;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
        tick();
    endtask

    task automatic pulse_step(input logic b);
        bus.burst = b;
        bus.step  = 1'b1;
        tick();
        bus.step  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.step   = 1'b0;
        bus.load   = 1'b0;
        bus.burst  = 1'b0;
        bus.mode   = 2'b00;
        bus.ser_in = 1'b0;
        bus.par_in = 8'h00;
`ifdef PSR_UNDO_EN
        bus.undo   = 1'b0;
`endif
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_q", 32'(bus.q), 32'h00);
        check("rst_ser", 32'(bus.ser_out), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_cnt", 32'(bus.step_cnt), 32'h0);
        rst = 1'b0;
        tick();

        // Load A5, then one SR step with ser_in=1
        push(8'hA5, 1'b0, 8'd0);
        do_load(8'hA5);
        bus.mode   = 2'b00;
        bus.ser_in = 1'b1;
        push(8'hD2, 1'b1, 8'd1);
        pulse_step(1'b0);
        check("single_busy", 32'(bus.busy), 32'h0);
        check("single_q", 32'(bus.q), 32'hD2);
        tick();

        // RL burst from 81
        push(8'h81, 1'b1, 8'd1);
        do_load(8'h81);
        bus.mode = 2'b11;
        push(8'h18, 1'b0, 8'd2);
        pulse_step(1'b0 | 1'b1);
        check("burst1_q", 32'(bus.q), 32'h03);
        check("burst1_busy", 32'(bus.busy), 32'h1);
        tick();
        check("burst2_q", 32'(bus.q), 32'h06);
        check("burst2_busy", 32'(bus.busy), 32'h1);
        tick();
        check("burst3_q", 32'(bus.q), 32'h0C);
        check("burst3_busy", 32'(bus.busy), 32'h1);
        tick();
        check("burst4_q", 32'(bus.q), 32'h18);
        check("burst4_busy", 32'(bus.busy), 32'h0);
        tick();

        // Burst with dropped step/load pulses and a mode change mid-burst
        push(8'h81, 1'b0, 8'd2);
        do_load(8'h81);
        push(8'h18, 1'b0, 8'd3);
        pulse_step(1'b1);
        bus.step   = 1'b1;
        bus.load   = 1'b1;
        bus.par_in = 8'hFF;
        bus.mode   = 2'b00;
        tick();
        bus.step = 1'b0;
        bus.load = 1'b0;
        check("drop_q2", 32'(bus.q), 32'h06);
        tick();
        check("drop_q3", 32'(bus.q), 32'h0C);
        tick();
        check("drop_q4", 32'(bus.q), 32'h18);
        tick();
        check("drop_cnt", 32'(bus.step_cnt), 32'd3);

        // Reset after the second shift of a burst
        push(8'h81, 1'b0, 8'd3);
        do_load(8'h81);
        bus.mode = 2'b11;
        pulse_step(1'b1);
        tick();
        check("abort_pre_q", 32'(bus.q), 32'h06);
        rst = 1'b1;
        #1;
        check("abort_q", 32'(bus.q), 32'h00);
        check("abort_ser", 32'(bus.ser_out), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_cnt", 32'(bus.step_cnt), 32'h0);
        check("abort_state", 32'(bus.state_dbg), 32'h0);
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Load and step together: load wins, step dropped
        bus.mode   = 2'b00;
        bus.ser_in = 1'b0;
        bus.burst  = 1'b0;
        bus.par_in = 8'h5A;
        bus.load   = 1'b1;
        bus.step   = 1'b1;
        push(8'h5A, 1'b0, 8'd0);
        tick();
        bus.load = 1'b0;
        bus.step = 1'b0;
        tick();

        // 256 accepted steps wrap step_cnt back to 0
        push(8'h00, 1'b0, 8'd0);
        do_load(8'h00);
        for (int i = 0; i < 256; i++) begin
            push(8'h00, 1'b0, 8'(i + 1));
            pulse_step(1'b0);
            tick();
        end
        check("wrap_cnt", 32'(bus.step_cnt), 32'd0);

`ifdef PSR_UNDO_EN
        push(8'h3C, 1'b0, 8'd0);
        do_load(8'h3C);
        bus.mode   = 2'b01;
        bus.ser_in = 1'b0;
        push(8'h78, 1'b0, 8'd1);
        pulse_step(1'b0);
        tick();
        push(8'h3C, 1'b0, 8'd1);
        bus.undo = 1'b1;
        tick();
        bus.undo = 1'b0;
        check("undo_q", 32'(bus.q), 32'h3C);
        tick();
        bus.undo = 1'b1;
        tick();
        bus.undo = 1'b0;
        check("undo2_done", 32'(bus.done), 32'h0);
        check("undo2_q", 32'(bus.q), 32'h3C);
        tick();
`endif

        repeat (4) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
